// File: rtl/btn_debounce_pkg.sv
// Shared types and default timing constants for the push-button debouncer.
// Consumers import btn_debounce_pkg::* to use the state enum in debug paths.
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int STABLE_TICKS_DEF = 20;
    localparam int LONG_TICKS_DEF   = 1000;
    localparam int CNT_W_DEF        = 10;

endpackage

// File: rtl/btn_sync2.sv
// Two-flop synchronizer for asynchronous pin inputs; both stages clear to 0
// on synchronous active-low reset.
module btn_sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/btn_debounce.sv
// Tick-driven button debouncer with registered level and press/release pulses.
// Define BTN_DEBOUNCE_LONG_PRESS_EN to build the hold counter behind long_press.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int STABLE_TICKS = STABLE_TICKS_DEF,
    parameter int LONG_TICKS   = LONG_TICKS_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic       clk_100Mhz,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       btn_raw,
    output logic       btn_level,
    output logic       btn_pressed,
    output logic       btn_released,
    output logic       long_press,
    output btn_state_t o_dbg_state
);

    localparam int MAX_TICKS = (STABLE_TICKS > LONG_TICKS) ? STABLE_TICKS : LONG_TICKS;
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_TICKS - 1);

    if ((64'd1 << CNT_W) <= 64'(MAX_TICKS - 1)) begin : g_bad_cnt_w
        $error("btn_debounce: CNT_W too narrow for STABLE_TICKS/LONG_TICKS");
    end

    logic       w_btn_s;
    btn_state_t r_state;
    logic [CNT_W-1:0] r_cnt;
    logic       r_level;
    logic       r_pressed;
    logic       r_released;

    btn_sync2 u_sync (
        .i_clk   (clk_100Mhz),
        .i_rst_n (rst_n),
        .i_d     (btn_raw),
        .o_q     (w_btn_s)
    );

    // A change of btn_s always wins over a coincident tick in the wait states.
    always_ff @(posedge clk_100Mhz) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_level    <= 1'b0;
            r_pressed  <= 1'b0;
            r_released <= 1'b0;
        end else begin
            r_pressed  <= 1'b0;
            r_released <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_btn_s) begin
                        r_state <= PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!w_btn_s) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (tick) begin
                        if (r_cnt == STABLE_LAST) begin
                            r_state   <= PRESSED;
                            r_cnt     <= '0;
                            r_level   <= 1'b1;
                            r_pressed <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                PRESSED: begin
                    if (!w_btn_s) begin
                        r_state <= RELEASE_WAIT;
                        r_cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (w_btn_s) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                    end else if (tick) begin
                        if (r_cnt == STABLE_LAST) begin
                            r_state    <= IDLE;
                            r_cnt      <= '0;
                            r_level    <= 1'b0;
                            r_released <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);

    logic             w_press_accept;
    logic [CNT_W-1:0] r_hold;
    logic             r_long_done;
    logic             r_long;

    assign w_press_accept = (r_state == PRESS_WAIT) && w_btn_s && tick && (r_cnt == STABLE_LAST);

    // Hold count survives RELEASE_WAIT so a release glitch resumes it; only a new press clears it.
    always_ff @(posedge clk_100Mhz) begin
        if (!rst_n) begin
            r_hold      <= '0;
            r_long_done <= 1'b0;
            r_long      <= 1'b0;
        end else begin
            r_long <= 1'b0;
            if (w_press_accept) begin
                r_hold      <= '0;
                r_long_done <= 1'b0;
            end else if ((r_state == PRESSED) && tick) begin
                if (r_hold != LONG_LAST) begin
                    r_hold <= r_hold + CNT_W'(1);
                end else if (!r_long_done) begin
                    r_long      <= 1'b1;
                    r_long_done <= 1'b1;
                end
            end
        end
    end

    assign long_press = r_long;
`else
    assign long_press = 1'b0;
`endif

    assign btn_level    = r_level;
    assign btn_pressed  = r_pressed;
    assign btn_released = r_released;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: STABLE_TICKS=4, LONG_TICKS=8, tick every 10 clocks.
// Expected pulses (kind + edge number) are queued by the stimulus and popped by a monitor.
module tb_btn_debounce;
    import btn_debounce_pkg::*;

    localparam int W = 32;
    localparam logic [3:0] K_PRESS = 4'd1;
    localparam logic [3:0] K_REL   = 4'd2;
    localparam logic [3:0] K_LONG  = 4'd4;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       btn_raw;
    logic       btn_level;
    logic       btn_pressed;
    logic       btn_released;
    logic       long_press;
    btn_state_t dbg_state;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    logic prev_level;

    btn_debounce #(
        .STABLE_TICKS (4),
        .LONG_TICKS   (8),
        .CNT_W        (10)
    ) dut (
        .clk_100Mhz   (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .btn_pressed  (btn_pressed),
        .btn_released (btn_released),
        .long_press   (long_press),
        .o_dbg_state  (dbg_state)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    task automatic pop_cmp(input logic [3:0] kind);
        logic [W-1:0] got;
        got = {kind, 28'(edge_cnt)};
        if (exp_q.size() == 0) check_eq("unexpected_pulse", got, '0);
        else check_eq("pulse", got, exp_q.pop_front());
    endtask

    // monitor: pulses against the scoreboard, level rise/fall aligned with pulses
    always @(negedge clk) begin
        if (btn_pressed === 1'b1)  pop_cmp(K_PRESS);
        if (btn_released === 1'b1) pop_cmp(K_REL);
        if (long_press === 1'b1)   pop_cmp(K_LONG);
        if (prev_level === 1'b0 && btn_level === 1'b1) check_eq("rise_with_press", W'(btn_pressed), W'(1));
        if (prev_level === 1'b1 && btn_level === 1'b0 && rst_n === 1'b1)
            check_eq("fall_with_release", W'(btn_released), W'(1));
        prev_level = btn_level;
    end

    // driver tasks
    task automatic cyc1(input logic t);
        tick = t;
        @(posedge clk);
        #1;
    endtask

    task automatic tick_period();
        repeat (9) cyc1(1'b0);
        cyc1(1'b1);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick_period();
    endtask

    task automatic expect_at(input logic [3:0] kind, input int edges_ahead);
        exp_q.push_back({kind, 28'(edge_cnt + edges_ahead)});
    endtask

    task automatic check_state(input string tag, input btn_state_t st, input logic lvl);
        check_eq({tag, "_state"}, W'(dbg_state), W'(st));
        check_eq({tag, "_level"}, W'(btn_level), W'(lvl));
    endtask

    task automatic press_full();
        btn_raw = 1'b1;
        ticks(3);
        check_state("pre_press", PRESS_WAIT, 1'b0);
        expect_at(K_PRESS, 10);
        tick_period();
        check_state("post_press", PRESSED, 1'b1);
    endtask

    task automatic release_full();
        btn_raw = 1'b0;
        ticks(3);
        check_state("pre_release", RELEASE_WAIT, 1'b1);
        expect_at(K_REL, 10);
        tick_period();
        check_state("post_release", IDLE, 1'b0);
    endtask

    task automatic drain(input string tag);
        repeat (3) cyc1(1'b0);
        check_eq(tag, W'(exp_q.size()), W'(0));
    endtask

    initial begin
        rst_n   = 1'b0;
        tick    = 1'b0;
        btn_raw = 1'b0;
        repeat (3) cyc1(1'b0);
        check_state("reset", IDLE, 1'b0);
        check_eq("reset_outs", W'({btn_pressed, btn_released, long_press}), W'(0));
        rst_n = 1'b1;
        cyc1(1'b0);

        // clean press then release
        press_full();
        ticks(2);
        release_full();
        drain("q_clean");

        // bounce every 15 clocks for 100 clocks, ticks running, then hold high
        for (int i = 0; i < 100; i++) begin
            btn_raw = ((i / 15) % 2) == 0;
            cyc1((i % 10) == 9);
        end
        ticks(2);
        expect_at(K_PRESS, 10);
        tick_period();
        check_state("bounce_press", PRESSED, 1'b1);
        ticks(2);
        release_full();
        drain("q_bounce");

        // btn_s drops on the same edge as the 4th tick in PRESS_WAIT
        btn_raw = 1'b1;
        ticks(3);
        repeat (7) cyc1(1'b0);
        btn_raw = 1'b0;
        cyc1(1'b0);
        cyc1(1'b0);
        cyc1(1'b1);
        check_state("simul", IDLE, 1'b0);
        ticks(1);
        check_state("simul_after", IDLE, 1'b0);
        drain("q_simul");

        // reset mid-count, then restart needs sync delay plus 4 full ticks
        btn_raw = 1'b1;
        ticks(3);
        rst_n = 1'b0;
        cyc1(1'b0);
        check_state("rst_mid", IDLE, 1'b0);
        check_eq("rst_mid_outs", W'({btn_pressed, btn_released, long_press}), W'(0));
        cyc1(1'b0);
        rst_n = 1'b1;
        cyc1(1'b0);
        cyc1(1'b0);
        check_state("rst_resync", IDLE, 1'b0);
        repeat (7) cyc1(1'b0);
        cyc1(1'b1);
        ticks(2);
        expect_at(K_PRESS, 10);
        tick_period();
        check_state("rst_repress", PRESSED, 1'b1);

        // reset while pressed clears the level without a release pulse
        rst_n   = 1'b0;
        btn_raw = 1'b0;
        cyc1(1'b0);
        check_state("rst_pressed", IDLE, 1'b0);
        cyc1(1'b0);
        rst_n = 1'b1;
        drain("q_reset");

        // long hold of 20 ticks
        press_full();
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
        ticks(7);
        expect_at(K_LONG, 10);
        tick_period();
        ticks(12);
`else
        ticks(20);
`endif
        check_eq("long_level", W'(btn_level), W'(1));
        release_full();
        drain("q_long");

        // release glitch of 2 ticks while pressed
        press_full();
        btn_raw = 1'b0;
        ticks(2);
        check_state("glitch_low", RELEASE_WAIT, 1'b1);
        btn_raw = 1'b1;
        ticks(4);
        check_state("glitch_back", PRESSED, 1'b1);
        release_full();
        drain("q_glitch");

        // tick stuck high: one count per clock
        btn_raw = 1'b1;
        repeat (6) cyc1(1'b1);
        expect_at(K_PRESS, 1);
        cyc1(1'b1);
        check_state("stuck_press", PRESSED, 1'b1);
        btn_raw = 1'b0;
        repeat (6) cyc1(1'b1);
        expect_at(K_REL, 1);
        cyc1(1'b1);
        check_state("stuck_release", IDLE, 1'b0);
        drain("q_stuck");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
